// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer/flag controller for an async FIFO: W_EN/W_ADDR are combinational (zero latency).
// Backpressure: writes are blocked while FULL; a blocked request sets the sticky OVERFLOW flag.
module fifo_wr_ctrl #(
  parameter int ADDR_WIDTH   = 3,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  W_INC,
  input  logic                  CLR_OVF,
  input  logic [ADDR_WIDTH:0]   R_PTR_GRAY,
  output logic                  W_EN,
  output logic [ADDR_WIDTH-1:0] W_ADDR,
  output logic [ADDR_WIDTH:0]   W_PTR_GRAY,
  output logic                  FULL,
  output logic                  ALMOST_FULL,
  output logic [ADDR_WIDTH:0]   W_LEVEL,
  output logic                  OVERFLOW
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);
  // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
  localparam logic [PW-1:0] FULL_MASK = {2'b11, {(PW-2){1'b0}}};

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic          ovf_q, ovf_d;
  logic [PW-1:0] rq_s;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] level;
  logic          full;

  assign rq_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    rbin_s = '0;
    for (int i = 0; i < PW; i++) begin
      rbin_s[i] = ^(rq_s >> i);
    end
  end

  assign full  = (wgray_q == (rq_s ^ FULL_MASK));
  assign level = wbin_q - rbin_s;

  assign W_EN        = W_INC & ~full;
  assign W_ADDR      = wbin_q[ADDR_WIDTH-1:0];
  assign W_PTR_GRAY  = wgray_q;
  assign FULL        = full;
  assign W_LEVEL     = level;
  assign ALMOST_FULL = (level >= AFULL_LVL);
  assign OVERFLOW    = ovf_q;

  always_comb begin
    wbin_d  = wbin_q;
    wgray_d = wgray_q;
    ovf_d   = ovf_q;
    if (W_EN) begin
      wbin_d  = wbin_q + PW'(1);
      wgray_d = wbin_d ^ (wbin_d >> 1);
    end
    if (CLR_OVF) begin
      ovf_d = 1'b0;
    end
    // Set has priority over clear so a simultaneous overflow is never lost.
    if (W_INC && full) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      wbin_q    <= wbin_d;
      wgray_q   <= wgray_d;
      ovf_q     <= ovf_d;
      sync_q[0] <= R_PTR_GRAY;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl at default parameters (ADDR_WIDTH=3, SYNC_STAGES=2, AFULL_THRESH=6).
module tb_fifo_wr_ctrl;

  logic       CLK;
  logic       RST;
  logic       W_INC;
  logic       CLR_OVF;
  logic [3:0] R_PTR_GRAY;
  logic       W_EN;
  logic [2:0] W_ADDR;
  logic [3:0] W_PTR_GRAY;
  logic       FULL;
  logic       ALMOST_FULL;
  logic [3:0] W_LEVEL;
  logic       OVERFLOW;

  int errors = 0;
  int checks = 0;

  fifo_wr_ctrl #(.ADDR_WIDTH(3), .SYNC_STAGES(2), .AFULL_THRESH(6)) dut (
    .CLK(CLK), .RST(RST), .W_INC(W_INC), .CLR_OVF(CLR_OVF), .R_PTR_GRAY(R_PTR_GRAY),
    .W_EN(W_EN), .W_ADDR(W_ADDR), .W_PTR_GRAY(W_PTR_GRAY), .FULL(FULL),
    .ALMOST_FULL(ALMOST_FULL), .W_LEVEL(W_LEVEL), .OVERFLOW(OVERFLOW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addr"}, 32'(W_ADDR), 0);
    chk({tag, "_gray"}, 32'(W_PTR_GRAY), 0);
    chk({tag, "_level"}, 32'(W_LEVEL), 0);
    chk({tag, "_full"}, 32'(FULL), 0);
    chk({tag, "_afull"}, 32'(ALMOST_FULL), 0);
    chk({tag, "_ovf"}, 32'(OVERFLOW), 0);
    chk({tag, "_wen"}, 32'(W_EN), 0);
  endtask

  function automatic logic [3:0] to_gray(input int x);
    return 4'(x ^ (x >> 1));
  endfunction

  logic [3:0] gray_tab [9];
  int wcount, rcount, rp1, rp2, lvl;
  logic       wen_exp;

  initial begin
    gray_tab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};
    RST = 1'b0; W_INC = 1'b0; CLR_OVF = 1'b0; R_PTR_GRAY = 4'h0;

    // 1. Asynchronous reset before any clock edge
    #3 RST = 1'b1;
    #1 chk_zero("rst_async");
    tick();
    tick();
    RST = 1'b0;
    #1 chk_zero("rst_release");

    // 2. Fill with the read pointer held at zero
    for (int k = 0; k < 9; k++) begin
      W_INC = 1'b1;
      #1;
      chk("fill_wen", 32'(W_EN), (k < 8) ? 1 : 0);
      chk("fill_addr", 32'(W_ADDR), k % 8);
      chk("fill_gray", 32'(W_PTR_GRAY), 32'(gray_tab[k]));
      chk("fill_level", 32'(W_LEVEL), k);
      chk("fill_afull", 32'(ALMOST_FULL), (k >= 6) ? 1 : 0);
      chk("fill_full", 32'(FULL), (k == 8) ? 1 : 0);
      chk("fill_ovf", 32'(OVERFLOW), 0);
      tick();
    end
    W_INC = 1'b0;
    chk("ovf_set", 32'(OVERFLOW), 1);
    chk("blocked_gray", 32'(W_PTR_GRAY), 32'hC);
    chk("blocked_addr", 32'(W_ADDR), 0);

    // 3. Read-pointer changes become visible after exactly two edges
    R_PTR_GRAY = 4'b0001;
    tick();
    chk("drain1_full_e1", 32'(FULL), 1);
    chk("drain1_level_e1", 32'(W_LEVEL), 8);
    tick();
    chk("drain1_full_e2", 32'(FULL), 0);
    chk("drain1_level_e2", 32'(W_LEVEL), 7);
    chk("drain1_afull", 32'(ALMOST_FULL), 1);
    R_PTR_GRAY = 4'b0011;
    tick();
    chk("drain2_level_e1", 32'(W_LEVEL), 7);
    tick();
    chk("drain2_level_e2", 32'(W_LEVEL), 6);
    chk("drain2_afull", 32'(ALMOST_FULL), 1);

    // 5. Overflow set beats clear; clear alone takes effect next edge
    W_INC = 1'b1;
    #1 chk("refill_wen0", 32'(W_EN), 1);
    tick();
    chk("refill_wen1", 32'(W_EN), 1);
    tick();
    chk("refill_full", 32'(FULL), 1);
    chk("refill_level", 32'(W_LEVEL), 8);
    CLR_OVF = 1'b1;
    #1 chk("setclr_wen", 32'(W_EN), 0);
    tick();
    chk("setclr_ovf", 32'(OVERFLOW), 1);
    chk("setclr_addr", 32'(W_ADDR), 2);
    W_INC = 1'b0;
    tick();
    chk("clr_ovf", 32'(OVERFLOW), 0);
    CLR_OVF = 1'b0;
    tick();
    chk("clr_ovf_hold", 32'(OVERFLOW), 0);
    chk("clr_full_hold", 32'(FULL), 1);

    // 4. Wrap with a model reader draining one entry every two cycles
    R_PTR_GRAY = 4'h0;
    RST = 1'b1;
    #1 RST = 1'b0;
    wcount = 0; rcount = 0; rp1 = 0; rp2 = 0;
    for (int i = 0; i < 200 && wcount < 20; i++) begin
      if ((i % 2) == 1 && rcount < wcount) rcount++;
      R_PTR_GRAY = to_gray(rcount);
      W_INC = 1'b1;
      #1;
      lvl = (wcount - rp2) & 15;
      wen_exp = (lvl != 8);
      chk("wrap_level", 32'(W_LEVEL), lvl);
      chk("wrap_full", 32'(FULL), (lvl == 8) ? 1 : 0);
      chk("wrap_afull", 32'(ALMOST_FULL), (lvl >= 6) ? 1 : 0);
      chk("wrap_wen", 32'(W_EN), 32'(wen_exp));
      chk("wrap_addr", 32'(W_ADDR), wcount % 8);
      chk("wrap_gray", 32'(W_PTR_GRAY), 32'(to_gray(wcount % 16)));
      if (wen_exp) wcount++;
      rp2 = rp1;
      rp1 = rcount;
      tick();
    end
    W_INC = 1'b0;
    #1;
    chk("wrap_total", wcount, 20);
    chk("wrap_end_addr", 32'(W_ADDR), 4);
    chk("wrap_end_gray", 32'(W_PTR_GRAY), 32'h6);

    // 6. Short reset pulse in the middle of operation
    R_PTR_GRAY = 4'h0;
    RST = 1'b1;
    #1 RST = 1'b0;
    tick();
    W_INC = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    W_INC = 1'b0;
    #1;
    chk("mid_level", 32'(W_LEVEL), 5);
    chk("mid_addr", 32'(W_ADDR), 5);
    RST = 1'b1;
    #1 chk_zero("mid_rst");
    #2 RST = 1'b0;
    tick();
    chk_zero("mid_after");
    W_INC = 1'b1;
    #1;
    chk("restart_wen", 32'(W_EN), 1);
    chk("restart_addr0", 32'(W_ADDR), 0);
    tick();
    chk("restart_addr1", 32'(W_ADDR), 1);
    chk("restart_gray1", 32'(W_PTR_GRAY), 1);
    W_INC = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
Write-side pointer and flag controller for the async FIFO. It sits directly upstream of the FIFO memory and drives its write address and write enable. It owns the write-domain binary/Gray pointers and synchronises the read-domain Gray pointer into the write clock. From these it produces FULL, ALMOST_FULL, the fill level and a sticky overflow error.

Parameters:
ADDR_WIDTH, 3, memory address width; DEPTH = 2**ADDR_WIDTH
SYNC_STAGES, 2, flops in the read-pointer synchroniser chain (legal range 2 to 4)
AFULL_THRESH, 6, fill level at which ALMOST_FULL asserts (legal range 1 to DEPTH)

Ports:
CLK  in  1  write-domain clock
RST  in  1  asynchronous, active-high reset
W_INC  in  1  write request from the producer
CLR_OVF  in  1  clears the OVERFLOW flag
R_PTR_GRAY  in  ADDR_WIDTH+1  read pointer in Gray code; asynchronous to CLK
W_EN  out  1  write strobe to the FIFO memory
W_ADDR  out  ADDR_WIDTH  write address to the FIFO memory
W_PTR_GRAY  out  ADDR_WIDTH+1  registered write pointer in Gray code, sent to the read domain
FULL  out  1  FIFO full
ALMOST_FULL  out  1  fill level >= AFULL_THRESH
W_LEVEL  out  ADDR_WIDTH+1  write-side view of occupancy, range 0 to DEPTH
OVERFLOW  out  1  sticky flag: a write was attempted while full

Behaviour:
- Single clock CLK. RST is asynchronous and active-high. RST high clears all state immediately, with no clock edge needed.
- State cleared by reset: binary pointer wbin, Gray register wgray, the synchroniser chain and OVERFLOW.
- Output values after reset: W_ADDR=0, W_PTR_GRAY=0, W_LEVEL=0, FULL=0, ALMOST_FULL=0, OVERFLOW=0, W_EN=0.
- W_EN = W_INC & ~FULL. This is combinational and has zero latency, so the memory captures data on the same edge.
- On each CLK edge with W_EN=1:
  - wbin <= wbin+1, wrapping modulo 2**(ADDR_WIDTH+1).
  - wgray <= gray(wbin+1), where gray(x) = x ^ (x>>1).
  - wbin and wgray update on the same edge, so W_PTR_GRAY is glitch-free.
- W_ADDR = wbin[ADDR_WIDTH-1:0]. The address wraps from DEPTH-1 to 0, and the extra MSB tracks the lap.
- Synchroniser:
  - R_PTR_GRAY passes through SYNC_STAGES flops to produce rq_s. No logic sits between the stages.
  - rbin_s = gray-to-binary(rq_s).
- W_LEVEL = wbin - rbin_s, computed modulo 2**(ADDR_WIDTH+1), combinationally from registered state.
- FULL = (wgray == {~rq_s[top two bits], rq_s[remaining bits]}). This is equivalent to W_LEVEL == DEPTH.
- ALMOST_FULL = (W_LEVEL >= AFULL_THRESH).
- Timing relative to the pointers:
  - A write that fills the FIFO asserts FULL immediately after that edge.
  - A read-pointer change is reflected in FULL, W_LEVEL and ALMOST_FULL exactly SYNC_STAGES CLK edges after it becomes stable at the input. This lag is pessimistic: FULL may stay high longer than necessary, but never reports free space that does not exist.
- OVERFLOW:
  - Set on an edge where W_INC=1 and FULL=1.
  - Cleared on an edge where CLR_OVF=1.
  - If set and clear occur together, set wins.
  - A blocked write leaves wbin, wgray and W_ADDR unchanged.
- R_PTR_GRAY may change at most one bit per read-domain update (Gray property). The block is not required to tolerate multi-bit jumps.
- Reset asserted mid-operation aborts cleanly. The read side must be reset in the same reset event; no pointer resynchronisation is attempted.

Test Plan:
1. Reset: drive RST=1 between clock edges -> all outputs read 0 immediately, before the next edge; release RST -> W_ADDR=0, FULL=0.
2. Fill (defaults), R_PTR_GRAY held at 0, W_INC=1 for 9 cycles:
   - W_EN high for the first 8 cycles; W_ADDR steps 0..7.
   - W_PTR_GRAY steps 0,1,3,2,6,7,5,4,C.
   - ALMOST_FULL rises after the 6th write.
   - FULL=1 and W_LEVEL=8 after the 8th write.
   - 9th request: W_EN=0 and OVERFLOW=1.
3. Drain visibility: from full, change R_PTR_GRAY to 0001 -> FULL falls and W_LEVEL=7 exactly 2 edges later; ALMOST_FULL stays 1; then R_PTR_GRAY=0011 -> W_LEVEL=6 two edges later, ALMOST_FULL remains 1.
4. Wrap: a model read side follows at 1 entry per 2 cycles for 20 writes -> W_ADDR wraps 7->0; W_PTR_GRAY passes 8 (gray of 15) then 0 (gray of 16 mod 16); FULL never asserts falsely; no write is lost.
5. Overflow clear: with FULL=1, drive W_INC=1 and CLR_OVF=1 on the same edge -> OVERFLOW stays 1; drive CLR_OVF alone -> OVERFLOW=0 on the next edge.
6. Reset mid-operation: at W_LEVEL=5, pulse RST for less than one clock period -> outputs clear asynchronously; the following writes start again at W_ADDR=0.
